// File: rtl/exu_cal.sv
// exu_cal -- shared execute-stage calculator.
//
// Responder on the calculator request interface used by the branch/jump
// unit and the other execute sub-units. XOR, CMP, ADD and SUB answer
// combinationally in the request cycle. SLL, SRL and SRA run on an
// iterative shifter that moves one bit per cycle, so the core carries
// no barrel shifter.
//
// Ports:
//   clk           core clock, all state on the rising edge
//   rst           asynchronous, active-high reset
//   hs_x4cal_val  request valid (requester holds op/operands until rdy)
//   hs_cal4x_rdy  result valid this cycle; transfer completes on val & rdy
//   i_op          one-hot op: [0]XOR [1]CMP [2]ADD [3]SUB [4]SLL [5]SRL [6]SRA
//   i_opn1        operand 1, pre-extended to bit 32 by the requester
//   i_opn2        operand 2, pre-extended to bit 32 by the requester
//   o_res         result, zero whenever rdy is low
//   o_busy        shifter is in SHIFT or DONE
module exu_cal (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs_x4cal_val,
    output logic        hs_cal4x_rdy,
    input  logic [6:0]  i_op,
    input  logic [32:0] i_opn1,
    input  logic [32:0] i_opn2,
    output logic [31:0] o_res,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] KIND_NONE = 2'd0;
    localparam logic [1:0] KIND_SLL  = 2'd1;
    localparam logic [1:0] KIND_SRL  = 2'd2;
    localparam logic [1:0] KIND_SRA  = 2'd3;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  kind_q, kind_d;

    logic        opOneHot;
    logic        opShift;
    logic [31:0] sumRes;
    logic [32:0] diffRes;
    logic        lessThan;
    logic [31:0] aluRes;
    logic [1:0]  kindSel;
    logic [31:0] shiftStep;

    // An op is legal only with exactly one bit set; x & (x-1) clears the
    // lowest set bit, so it is zero exactly when at most one bit is set.
    assign opOneHot = (i_op != 7'd0) && ((i_op & (i_op - 7'd1)) == 7'd0);
    assign opShift  = opOneHot && (|i_op[6:4]);

    // Only the low 32 bits of the sum are ever returned, so the 33rd
    // operand bit cannot affect it. The difference stays 33-bit wide to
    // match the requester's extension, with its carry-out discarded.
    assign sumRes   = i_opn1[31:0] + i_opn2[31:0];
    assign diffRes  = i_opn1 - i_opn2;
    assign lessThan = $signed(i_opn1) < $signed(i_opn2);

    // Single-cycle result mux; only consulted when the op is one-hot.
    always_comb begin
        aluRes = 32'd0;
        if (i_op[0]) begin
            aluRes = i_opn1[31:0] ^ i_opn2[31:0];
        end else if (i_op[1]) begin
            aluRes = {31'd0, lessThan};
        end else if (i_op[2]) begin
            aluRes = sumRes;
        end else if (i_op[3]) begin
            aluRes = diffRes[31:0];
        end
    end

    // Shift kind captured at accept time, and one-bit step of the shifter.
    always_comb begin
        kindSel = KIND_SRA;
        if (i_op[4]) begin
            kindSel = KIND_SLL;
        end else if (i_op[5]) begin
            kindSel = KIND_SRL;
        end
        case (kind_q)
            KIND_SLL: shiftStep = {acc_q[30:0], 1'b0};
            KIND_SRL: shiftStep = {1'b0, acc_q[31:1]};
            KIND_SRA: shiftStep = {acc_q[31], acc_q[31:1]};
            default:  shiftStep = acc_q;
        endcase
    end

    // Next-state and handshake logic. Dropping val in SHIFT or DONE is an
    // abort and always lands back in IDLE; DONE never accepts a new request.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        kind_d       = kind_q;
        hs_cal4x_rdy = 1'b0;
        o_res        = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (hs_x4cal_val) begin
                    if (opShift) begin
                        acc_d   = i_opn1[31:0];
                        cnt_d   = i_opn2[4:0];
                        kind_d  = kindSel;
                        state_d = ST_SHIFT;
                    end else begin
                        hs_cal4x_rdy = 1'b1;
                        o_res        = opOneHot ? aluRes : 32'd0;
                    end
                end
            end
            ST_SHIFT: begin
                if (!hs_x4cal_val) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 5'd0) begin
                    state_d = ST_DONE;
                end else begin
                    acc_d = shiftStep;
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (hs_x4cal_val) begin
                    hs_cal4x_rdy = 1'b1;
                    o_res        = acc_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset drops straight to IDLE with no rdy pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= 32'd0;
            cnt_q   <= 5'd0;
            kind_q  <= KIND_NONE;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
        end
    end

    assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_exu_cal.sv
// tb_exu_cal -- self-checking bench for exu_cal.
//
// Expected results and latencies are pushed to scoreboard queues when a
// request is driven and popped when the DUT raises rdy. Inputs change
// 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_exu_cal;

    localparam logic [6:0] OP_XOR = 7'b0000001;
    localparam logic [6:0] OP_CMP = 7'b0000010;
    localparam logic [6:0] OP_ADD = 7'b0000100;
    localparam logic [6:0] OP_SUB = 7'b0001000;
    localparam logic [6:0] OP_SLL = 7'b0010000;
    localparam logic [6:0] OP_SRL = 7'b0100000;
    localparam logic [6:0] OP_SRA = 7'b1000000;

    logic        clk;
    logic        rst;
    logic        val;
    logic        rdy;
    logic [6:0]  op;
    logic [32:0] opn1;
    logic [32:0] opn2;
    logic [31:0] res;
    logic        busy;

    int checks;
    int errors;

    logic [31:0] expResQ[$];
    int          expLatQ[$];

    exu_cal dut (
        .clk          (clk),
        .rst          (rst),
        .hs_x4cal_val (val),
        .hs_cal4x_rdy (rdy),
        .i_op         (op),
        .i_opn1       (opn1),
        .i_opn2       (opn2),
        .o_res        (res),
        .o_busy       (busy)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model, written with plain operators rather than stepping.
    function automatic logic [31:0] model(input logic [6:0] mop,
                                          input logic [32:0] a,
                                          input logic [32:0] b);
        logic signed [31:0] sa;
        logic [32:0]        d;
        sa = a[31:0];
        d  = a - b;
        case (mop)
            OP_XOR:  return a[31:0] ^ b[31:0];
            OP_CMP:  return {31'd0, ($signed(a) < $signed(b))};
            OP_ADD:  return a[31:0] + b[31:0];
            OP_SUB:  return d[31:0];
            OP_SLL:  return a[31:0] << b[4:0];
            OP_SRL:  return a[31:0] >> b[4:0];
            OP_SRA:  return sa >>> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    // Drives one request and waits (bounded) for rdy. Leaves the bench at
    // the falling edge of the rdy cycle so a follow-up request can be
    // driven back-to-back. lat = -1 means rdy never arrived.
    task automatic issue(input logic [6:0] iop, input logic [32:0] a,
                         input logic [32:0] b, output logic [31:0] gotRes,
                         output int lat, output int busyPre,
                         output logic busyRdy);
        @(posedge clk);
        #1;
        val  = 1'b1;
        op   = iop;
        opn1 = a;
        opn2 = b;
        lat     = -1;
        busyPre = 0;
        busyRdy = 1'b0;
        gotRes  = 32'd0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (rdy === 1'b1) begin
                lat     = c;
                gotRes  = res;
                busyRdy = busy;
                break;
            end
            if (busy === 1'b1) busyPre++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        val  = 1'b0;
        op   = 7'd0;
        opn1 = 33'd0;
        opn2 = 33'd0;
    endtask

    task automatic test_reset();
        val  = 1'b0;
        op   = 7'd0;
        opn1 = 33'd0;
        opn2 = 33'd0;
        rst  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy got %b expected 0", busy);
        end
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_rdy got %b expected 0", rdy);
        end
        checks++;
        if (res !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_res got %h expected 00000000", res);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [6:0]  ops[5];
        logic [32:0] as[5];
        logic [32:0] bs[5];
        string       names[5];
        logic [31:0] gotRes;
        logic [31:0] expRes;
        int          lat, expLat, busyPre;
        logic        busyRdy;
        ops = '{OP_ADD, OP_CMP, OP_CMP, OP_XOR, OP_SUB};
        as  = '{33'h0_FFFFFFFF, 33'h1_FFFFFFFF, 33'h0_FFFFFFFF,
                33'h0_A5A5A5A5, 33'h0_00000003};
        bs  = '{33'h0_00000001, 33'h0_00000001, 33'h0_00000001,
                33'h0_FFFF0000, 33'h0_00000005};
        names = '{"add_wrap", "cmp_signed", "cmp_unsigned", "xor", "sub_neg"};
        expResQ.push_back(32'h00000000);
        expResQ.push_back(32'h00000001);
        expResQ.push_back(32'h00000000);
        expResQ.push_back(32'h5A5AA5A5);
        expResQ.push_back(32'hFFFFFFFE);
        for (int i = 0; i < 5; i++) begin
            expLatQ.push_back(0);
            issue(ops[i], as[i], bs[i], gotRes, lat, busyPre, busyRdy);
            expRes = expResQ.pop_front();
            expLat = expLatQ.pop_front();
            checks++;
            if (lat != expLat) begin
                errors++;
                $display("[TB] FAIL %s_lat got %0d expected %0d", names[i], lat, expLat);
            end
            checks++;
            if (gotRes !== expRes) begin
                errors++;
                $display("[TB] FAIL %s_res got %h expected %h", names[i], gotRes, expRes);
            end
            idle();
        end
    endtask

    task automatic test_illegal();
        logic [6:0]  badOps[2];
        logic [31:0] gotRes;
        logic [31:0] expRes;
        int          lat, expLat, busyPre;
        logic        busyRdy;
        badOps = '{7'b0000011, 7'b0000000};
        for (int i = 0; i < 2; i++) begin
            expResQ.push_back(32'd0);
            expLatQ.push_back(0);
            issue(badOps[i], 33'h0_12345678, 33'h0_0000_0003, gotRes, lat, busyPre, busyRdy);
            expRes = expResQ.pop_front();
            expLat = expLatQ.pop_front();
            checks++;
            if (lat != expLat) begin
                errors++;
                $display("[TB] FAIL illegal%0d_lat got %0d expected %0d", i, lat, expLat);
            end
            checks++;
            if (gotRes !== expRes) begin
                errors++;
                $display("[TB] FAIL illegal%0d_res got %h expected %h", i, gotRes, expRes);
            end
            checks++;
            if (busyRdy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL illegal%0d_busy got %b expected 0", i, busyRdy);
            end
            idle();
        end
    endtask

    task automatic test_sra();
        logic [31:0] gotRes;
        logic [31:0] expRes;
        int          lat, expLat, busyPre;
        logic        busyRdy;
        expResQ.push_back(32'hF8000001);
        expLatQ.push_back(6);
        issue(OP_SRA, 33'h0_80000010, 33'h0_00000004, gotRes, lat, busyPre, busyRdy);
        expRes = expResQ.pop_front();
        expLat = expLatQ.pop_front();
        checks++;
        if (lat != expLat) begin
            errors++;
            $display("[TB] FAIL sra_lat got %0d expected %0d", lat, expLat);
        end
        checks++;
        if (gotRes !== expRes) begin
            errors++;
            $display("[TB] FAIL sra_res got %h expected %h", gotRes, expRes);
        end
        checks++;
        if (busyPre != 5) begin
            errors++;
            $display("[TB] FAIL sra_busy_cycles got %0d expected 5", busyPre);
        end
        checks++;
        if (busyRdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sra_busy_done got %b expected 1", busyRdy);
        end
        idle();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sra_busy_after got %b expected 0", busy);
        end
    endtask

    task automatic test_shift_extremes();
        logic [31:0] gotRes;
        logic [31:0] expRes;
        int          lat, expLat, busyPre;
        logic        busyRdy;
        expResQ.push_back(32'h00000001);
        expLatQ.push_back(2);
        issue(OP_SLL, 33'h0_00000001, 33'h0_00000000, gotRes, lat, busyPre, busyRdy);
        expRes = expResQ.pop_front();
        expLat = expLatQ.pop_front();
        checks++;
        if (lat != expLat) begin
            errors++;
            $display("[TB] FAIL sll0_lat got %0d expected %0d", lat, expLat);
        end
        checks++;
        if (gotRes !== expRes) begin
            errors++;
            $display("[TB] FAIL sll0_res got %h expected %h", gotRes, expRes);
        end
        idle();
        expResQ.push_back(32'h00000001);
        expLatQ.push_back(33);
        issue(OP_SRL, 33'h0_80000000, 33'h0_0000001F, gotRes, lat, busyPre, busyRdy);
        expRes = expResQ.pop_front();
        expLat = expLatQ.pop_front();
        checks++;
        if (lat != expLat) begin
            errors++;
            $display("[TB] FAIL srl31_lat got %0d expected %0d", lat, expLat);
        end
        checks++;
        if (gotRes !== expRes) begin
            errors++;
            $display("[TB] FAIL srl31_res got %h expected %h", gotRes, expRes);
        end
        idle();
    endtask

    // SLL by 20 abandoned at T+5, either by dropping val or by reset,
    // then an ADD presented in the first idle cycle.
    task automatic test_abort(input bit useReset);
        logic        sawRdy;
        logic [31:0] expRes;
        string       tag;
        tag    = useReset ? "rst_abort" : "val_abort";
        sawRdy = 1'b0;
        @(posedge clk);
        #1;
        val  = 1'b1;
        op   = OP_SLL;
        opn1 = 33'h0_00000001;
        opn2 = 33'h0_00000014;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rdy !== 1'b0) sawRdy = 1'b1;
            @(posedge clk);
            #1;
        end
        val = 1'b0;
        op  = 7'd0;
        if (useReset) begin
            rst = 1'b1;
            #1;
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s_busy_now got %b expected 0", tag, busy);
            end
            @(negedge clk);
            if (rdy !== 1'b0) sawRdy = 1'b1;
            rst = 1'b0;
        end else begin
            @(negedge clk);
            if (rdy !== 1'b0) sawRdy = 1'b1;
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s_busy_t5 got %b expected 1", tag, busy);
            end
        end
        checks++;
        if (sawRdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_no_rdy got %b expected 0", tag, sawRdy);
        end
        expResQ.push_back(32'd5);
        @(posedge clk);
        #1;
        val  = 1'b1;
        op   = OP_ADD;
        opn1 = 33'h0_00000002;
        opn2 = 33'h0_00000003;
        @(negedge clk);
        expRes = expResQ.pop_front();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_busy_t6 got %b expected 0", tag, busy);
        end
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_add_rdy got %b expected 1", tag, rdy);
        end
        checks++;
        if (res !== expRes) begin
            errors++;
            $display("[TB] FAIL %s_add_res got %h expected %h", tag, res, expRes);
        end
        idle();
    endtask

    // Alternating shift / single-cycle requests with no idle gap between
    // a completed transfer and the next request.
    task automatic test_back_to_back();
        logic [6:0]  seqOps[6];
        logic [6:0]  curOp;
        logic [32:0] a, b;
        logic [31:0] gotRes;
        logic [31:0] expRes;
        int          lat, expLat, busyPre;
        logic        busyRdy;
        seqOps = '{OP_SRL, OP_ADD, OP_SRA, OP_SUB, OP_SLL, OP_XOR};
        for (int i = 0; i < 6; i++) begin
            curOp = seqOps[i];
            a = {1'b0, $urandom()};
            b = {1'b0, $urandom()};
            if (i == 2) a[31] = 1'b1;
            if (curOp[4] || curOp[5] || curOp[6]) b[4:0] = 5'($urandom_range(1, 12));
            expResQ.push_back(model(curOp, a, b));
            expLatQ.push_back((curOp[4] || curOp[5] || curOp[6]) ? int'(b[4:0]) + 2 : 0);
            issue(curOp, a, b, gotRes, lat, busyPre, busyRdy);
            expRes = expResQ.pop_front();
            expLat = expLatQ.pop_front();
            checks++;
            if (lat != expLat) begin
                errors++;
                $display("[TB] FAIL b2b%0d_lat got %0d expected %0d", i, lat, expLat);
            end
            checks++;
            if (gotRes !== expRes) begin
                errors++;
                $display("[TB] FAIL b2b%0d_res got %h expected %h", i, gotRes, expRes);
            end
        end
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        test_reset();
        test_single();
        test_illegal();
        test_sra();
        test_shift_extremes();
        test_abort(1'b0);
        test_abort(1'b1);
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
